// File: rtl/param_bin_counter.sv
// Up/down event counter with prescaled stepping, synchronous load, and
// wrap / saturate / one-shot terminal behaviour driving a stretched flag.
module param_bin_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int FLAG_LEN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             flag,
    output logic             busy,
    output logic             done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = $clog2(FLAG_LEN + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FLAG_INIT = FW'(FLAG_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] presc;
    logic [FW-1:0] flag_cnt;
    logic          sat_hold;
    logic          is_sat;
    logic          is_oneshot;
    logic          tick;
    logic          step;
    logic          terminal;
    logic          flag_evt;
    logic          enter_run;

    // stop and load both swallow the prescaler advance and any pending step
    always_comb begin
        is_sat     = (mode == 2'b01);
        is_oneshot = (mode == 2'b10);
        tick       = (state == RUN) && en && !stop && !load;
        step       = tick && (presc == PRE_LAST);
        terminal   = step && (up_dn ? (count >= max_val) : (count == '0));
        flag_evt   = terminal && !(is_sat && sat_hold);
        state_nx   = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                if (stop) state_nx = IDLE;
                else if (terminal && is_oneshot) state_nx = DONE;
            end
            DONE: begin
                if (load) state_nx = IDLE;
                else if (start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
        enter_run = (state != RUN) && (state_nx == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            presc    <= '0;
            count    <= '0;
            flag_cnt <= '0;
            flag     <= 1'b0;
            sat_hold <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);

            if (load || enter_run) presc <= '0;
            else if (tick) presc <= step ? '0 : presc + 1'b1;

            if (load) count <= load_val;
            else if (step && !terminal) count <= up_dn ? count + 1'b1 : count - 1'b1;
            else if (terminal && !is_sat && !is_oneshot) count <= up_dn ? '0 : max_val;

            // a blocked saturating step re-arms nothing until the count moves again
            if (load) sat_hold <= 1'b0;
            else if (step) sat_hold <= terminal && is_sat;

            if (flag_evt) flag_cnt <= FLAG_INIT;
            else if (flag_cnt != '0) flag_cnt <= flag_cnt - 1'b1;
            flag <= flag_evt || (flag_cnt > FW'(1));
        end
    end
endmodule

// File: tb/tb_param_bin_counter.sv
// Two counters (prescale 1 / flag 1 and prescale 4 / flag 3) share stimulus;
// a cycle model checks both every cycle, directed literals pin the model.
module tb_param_bin_counter;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic       clk = 1'b0;
    logic       reset_n, start, stop, en, up_dn, load;
    logic [1:0] mode;
    logic [7:0] load_val, max_val;
    logic [7:0] cnt_a, cnt_b;
    logic       flg_a, bsy_a, dn_a, flg_b, bsy_b, dn_b;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    typedef struct {
        int cnt;
        int st;
        int pre;
        int fl;
        bit blk;
    } mdl_t;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    param_bin_counter #(.WIDTH(8), .PRESCALE(1), .FLAG_LEN(1)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .en(en),
        .up_dn(up_dn), .mode(mode), .load(load), .load_val(load_val),
        .max_val(max_val), .count(cnt_a), .flag(flg_a), .busy(bsy_a), .done(dn_a)
    );

    param_bin_counter #(.WIDTH(8), .PRESCALE(4), .FLAG_LEN(3)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .en(en),
        .up_dn(up_dn), .mode(mode), .load(load), .load_val(load_val),
        .max_val(max_val), .count(cnt_b), .flag(flg_b), .busy(bsy_b), .done(dn_b)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural next-cycle rule: one enabled RUN cycle = one prescaler tick,
    // every P ticks the count moves by one (mod 256) unless it hits the bound.
    function automatic mdl_t mnext(input mdl_t s, input int p, input int fl);
        mdl_t n;
        bit   moving, stepping, term;
        n = s;
        if (!reset_n) begin
            n.cnt = 0; n.st = S_IDLE; n.pre = 0; n.fl = 0; n.blk = 1'b0;
            return n;
        end
        moving   = (s.st == S_RUN) && en && !stop && !load;
        stepping = moving && (s.pre + 1 == p);
        term     = stepping && (up_dn ? (s.cnt >= int'(max_val)) : (s.cnt == 0));
        n.fl = (s.fl > 0) ? s.fl - 1 : 0;
        if (term && !(mode == 2'b01 && s.blk)) n.fl = fl;
        if (moving) n.pre = (s.pre + 1) % p;
        if (load) n.cnt = int'(load_val);
        else if (stepping && !term) n.cnt = up_dn ? (s.cnt + 1) % 256 : (s.cnt + 255) % 256;
        else if (term && (mode == 2'b00 || mode == 2'b11)) n.cnt = up_dn ? 0 : int'(max_val);
        if (load) n.blk = 1'b0;
        else if (stepping) n.blk = term && (mode == 2'b01);
        if (s.st == S_IDLE && start) begin
            n.st = S_RUN; n.pre = 0;
        end else if (s.st == S_RUN) begin
            if (stop) n.st = S_IDLE;
            else if (term && mode == 2'b10) n.st = S_DONE;
        end else if (s.st == S_DONE) begin
            if (load) n.st = S_IDLE;
            else if (start) begin n.st = S_RUN; n.pre = 0; end
        end
        if (load) n.pre = 0;
        return n;
    endfunction

    always @(posedge clk) begin
        ma = mnext(ma, 1, 1);
        mb = mnext(mb, 4, 3);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("a_count", int'(cnt_a), ma.cnt);
            check("a_flag",  int'(flg_a), int'(ma.fl > 0));
            check("a_busy",  int'(bsy_a), int'(ma.st == S_RUN));
            check("a_done",  int'(dn_a),  int'(ma.st == S_DONE));
            check("b_count", int'(cnt_b), mb.cnt);
            check("b_flag",  int'(flg_b), int'(mb.fl > 0));
            check("b_busy",  int'(bsy_b), int'(mb.st == S_RUN));
            check("b_done",  int'(dn_b),  int'(mb.st == S_DONE));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        ma = '{0, S_IDLE, 0, 0, 1'b0};
        mb = '{0, S_IDLE, 0, 0, 1'b0};
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1; up_dn = 1'b1;
        mode = 2'b00; load = 1'b0; load_val = 8'h00; max_val = 8'd9;
        cyc();
        chk_on = 1'b1;
        cyc();
        check("rst_count", int'(cnt_a), 0);
        check("rst_busy",  int'(bsy_a), 0);
        check("rst_flag",  int'(flg_a), 0);
        check("rst_done",  int'(dn_a),  0);
        reset_n = 1'b1;

        // wrap up, max 9: 0..9,0 with one-cycle flag each wrap
        start = 1'b1; cyc(); start = 1'b0;
        check("t2_first_count", int'(cnt_a), 0);
        check("t2_busy", int'(bsy_a), 1);
        for (int i = 1; i <= 23; i++) begin
            cyc();
            check("t2_count", int'(cnt_a), i % 10);
            check("t2_flag", int'(flg_a), int'(i % 10 == 0));
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        check("t2_stop_busy", int'(bsy_a), 0);
        check("t2_stop_held", int'(cnt_a), 3);
        cyc();
        check("t2_idle_held", int'(cnt_a), 3);

        // prescale 4, down from 2, max 5, flag 3 cycles, en-low freeze
        up_dn = 1'b0; max_val = 8'd5; load = 1'b1; load_val = 8'd2; start = 1'b1;
        cyc(); load = 1'b0; start = 1'b0;
        check("t3_load", int'(cnt_b), 2);
        check("t3_busy", int'(bsy_b), 1);
        for (int j = 1; j <= 15; j++) begin
            cyc();
            check("t3_count", int'(cnt_b), (j < 4) ? 2 : (j < 8) ? 1 : (j < 12) ? 0 : 5);
            check("t3_flag", int'(flg_b), int'(j >= 12 && j <= 14));
        end
        en = 1'b0;
        for (int j = 16; j <= 21; j++) begin
            cyc();
            check("t3_freeze", int'(cnt_b), 5);
        end
        en = 1'b1;
        cyc();
        check("t3_resume", int'(cnt_b), 4);
        cyc(); cyc(); cyc();
        check("t3_hold4", int'(cnt_b), 4);
        cyc();
        check("t3_next", int'(cnt_b), 3);
        stop = 1'b1; cyc(); stop = 1'b0;

        // saturate up to 3
        mode = 2'b01; max_val = 8'd3; up_dn = 1'b1; load = 1'b1; load_val = 8'd0; start = 1'b1;
        cyc(); load = 1'b0; start = 1'b0;
        check("t4_load", int'(cnt_a), 0);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            check("t4_count", int'(cnt_a), (j <= 3) ? j : 3);
            check("t4_flag", int'(flg_a), int'(j == 4));
        end
        up_dn = 1'b0; cyc();
        check("t4_down", int'(cnt_a), 2);
        up_dn = 1'b1; cyc();
        check("t4_up", int'(cnt_a), 3);
        check("t4_noflag", int'(flg_a), 0);
        cyc();
        check("t4_reflag", int'(flg_a), 1);
        check("t4_stuck", int'(cnt_a), 3);
        cyc();
        check("t4_flag_off", int'(flg_a), 0);
        stop = 1'b1; cyc(); stop = 1'b0;

        // one-shot to 4
        mode = 2'b10; max_val = 8'd4; load = 1'b1; load_val = 8'd0; start = 1'b1;
        cyc(); load = 1'b0; start = 1'b0;
        check("t5_busy", int'(bsy_a), 1);
        for (int j = 1; j <= 4; j++) begin
            cyc();
            check("t5_count", int'(cnt_a), j);
            check("t5_run", int'(bsy_a), 1);
        end
        cyc();
        check("t5_done", int'(dn_a), 1);
        check("t5_idle_busy", int'(bsy_a), 0);
        check("t5_held", int'(cnt_a), 4);
        check("t5_flag", int'(flg_a), 1);
        cyc(); cyc();
        check("t5_still_done", int'(dn_a), 1);
        start = 1'b1; cyc(); start = 1'b0;
        check("t5_restart_busy", int'(bsy_a), 1);
        check("t5_restart_done", int'(dn_a), 0);
        cyc();
        check("t5_redone", int'(dn_a), 1);
        check("t5_recount", int'(cnt_a), 4);

        // collisions: load beats start in DONE, load beats step, stop beats start
        mode = 2'b00; max_val = 8'hFF; load = 1'b1; load_val = 8'h10; start = 1'b1;
        cyc(); load = 1'b0; start = 1'b0;
        check("t6_done_load_busy", int'(bsy_a), 0);
        check("t6_done_load_done", int'(dn_a), 0);
        check("t6_done_load_cnt", int'(cnt_a), 16);
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        check("t6_step", int'(cnt_a), 17);
        load = 1'b1; load_val = 8'hF0; cyc(); load = 1'b0;
        check("t6_load_wins", int'(cnt_a), 240);
        cyc();
        check("t6_after_load", int'(cnt_a), 241);
        stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
        check("t6_stop_busy", int'(bsy_a), 0);
        check("t6_stop_cnt", int'(cnt_a), 241);

        // reset mid-run
        load = 1'b1; load_val = 8'h37; start = 1'b1; cyc(); load = 1'b0;
        check("t1_pre_cnt", int'(cnt_a), 55);
        check("t1_pre_busy", int'(bsy_a), 1);
        reset_n = 1'b0; cyc();
        check("t1_cnt", int'(cnt_a), 0);
        check("t1_busy", int'(bsy_a), 0);
        check("t1_flag", int'(flg_a), 0);
        check("t1_done", int'(dn_a), 0);
        cyc();
        check("t1_start_ignored", int'(bsy_a), 0);
        reset_n = 1'b1; start = 1'b0; cyc();
        check("t1_idle", int'(bsy_a), 0);

        for (int k = 0; k < 4000; k++) begin
            reset_n  = ($urandom_range(0, 199) != 0);
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 24) == 0);
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0)
                max_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            load_val = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 14));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
